// File: rtl/fpu_pkg.sv
// fpu_pkg: shared float constants, field positions and types for the float-to-int path
// No ports; imported by ftoi_round_shift and ftoi_pipe.
package fpu_pkg;
  localparam logic [7:0] EXP_BIAS      = 8'd127;
  localparam logic [7:0] FTOI_EXP_ZERO = 8'd150;
  localparam logic [7:0] FTOI_EXP_MAX  = 8'd158;
  // Smallest exponent whose value can round up to 1 (0.5 <= |x| < 1)
  localparam logic [7:0] FTOI_EXP_RND  = FTOI_EXP_ZERO - 8'd24;
  localparam logic [31:0] INT32_MAX = 32'h7fffffff;
  localparam logic [31:0] INT32_MIN = 32'h80000000;
  localparam int SIGN_POS = 31;
  localparam int EXP_HI   = 30;
  localparam int EXP_LO   = 23;
  localparam int FRAC_HI  = 22;
  localparam int FRAC_LO  = 0;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } float_t;
  typedef enum logic [1:0] {CL_NUM, CL_MIN, CL_SAT, CL_NAN} ftoi_cls_t;
  typedef struct packed {
    logic        sign;
    logic [31:0] mag;
    logic        rbit;
    ftoi_cls_t   cls;
  } ftoi_s1_t;
endpackage

// File: rtl/ftoi_round_shift.sv
// ftoi_round_shift: aligns the 24-bit significand to an integer magnitude and extracts the round bit
// Ports: m (significand {1,f}), exp (biased exponent) -> mag (unrounded magnitude), rbit (last bit shifted out).
module ftoi_round_shift
  import fpu_pkg::*;
(
  input  logic [23:0] m,
  input  logic [7:0]  exp,
  output logic [31:0] mag,
  output logic        rbit
);
  logic [7:0]  rsh, lsh;
  logic [24:0] w;
  assign rsh = FTOI_EXP_ZERO - exp;
  assign lsh = exp - FTOI_EXP_ZERO;
  // One extra low bit catches the round bit, so a 24-bit shift still yields rbit=M[23]
  assign w = {m, 1'b0} >> rsh[4:0];
  always_comb begin
    mag  = exp < FTOI_EXP_RND ? 32'd0 :
           exp < FTOI_EXP_ZERO ? {8'd0, w[24:1]} :
           exp < FTOI_EXP_MAX ? {8'd0, m} << lsh[2:0] : 32'd0;
    rbit = exp >= FTOI_EXP_RND && exp < FTOI_EXP_ZERO && w[0];
  end
endmodule

// File: rtl/ftoi_pipe.sv
// ftoi_pipe: two-stage float32 to int32 converter, round half away from zero, saturating
// Ports: clk, rst (async active-high); in_valid/in_ready/in_data (float in);
//        out_valid/out_ready/out_data (int32 out), out_ovf (saturated or Inf/NaN).
module ftoi_pipe
  import fpu_pkg::*;
#(
  parameter logic [31:0] NAN_VAL = 32'h7fffffff
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_ovf
);
  float_t      f;
  ftoi_cls_t   cls;
  ftoi_s1_t    s1;
  logic [31:0] mag, rnd, sgn, res;
  logic        rbit, ovf, s1_valid, s2_valid, s1_en, s2_en;
  assign f         = in_data;
  assign s2_en     = !s2_valid || out_ready;
  assign s1_en     = !s1_valid || s2_en;
  assign in_ready  = s1_en;
  assign out_valid = s2_valid;
  ftoi_round_shift u_rs (
    .m   ({1'b1, f.frac}),
    .exp (f.exp),
    .mag (mag),
    .rbit(rbit)
  );
  // -2^31 is the only e=158 value that fits, so it is exact rather than saturated
  assign cls = (f.exp == 8'hff && f.frac != 23'd0) ? CL_NAN :
               f.exp < FTOI_EXP_MAX ? CL_NUM :
               (f.exp == FTOI_EXP_MAX && f.sign && f.frac == 23'd0) ? CL_MIN : CL_SAT;
  always_comb begin
    rnd = s1.mag + 32'(s1.rbit);
    sgn = s1.sign ? -rnd : rnd;
    res = s1.cls == CL_NAN ? NAN_VAL :
          s1.cls == CL_SAT ? (s1.sign ? INT32_MIN : INT32_MAX) :
          s1.cls == CL_MIN ? INT32_MIN : sgn;
    ovf = s1.cls == CL_NAN || s1.cls == CL_SAT;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1       <= '0;
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else begin
      if (s1_en) begin
        s1_valid <= in_valid;
        if (in_valid) s1 <= '{sign: f.sign, mag: mag, rbit: rbit, cls: cls};
      end
      if (s2_en) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= res;
          out_ovf  <= ovf;
        end
      end
    end
  end
endmodule

// File: doc/ftoi_pipe.md
Name: ftoi_pipe

Overview:
- Pipelined float-to-integer converter. Consumes IEEE-754 single-precision words, e.g. results of the FPU datapath or the integer-to-float unit.
- Produces signed 32-bit two's-complement integers.
- Rounding is to nearest, ties away from zero on magnitude, which matches the half-up guard rounding of the integer-to-float unit. Out-of-range results saturate.
- Two register stages with valid/ready handshake on both sides, so it drops into the FPU result path with backpressure.

Parameters:
- NAN_VAL, 32'h7fffffff, result driven for NaN inputs (exp=255, frac!=0).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  32  float {s[31], e[30:23], f[22:0]}.
- out_valid  output  1  out_data/out_ovf are valid.
- out_ready  input  1  consumer accepts the output this cycle.
- out_data  output  32  signed integer result.
- out_ovf  output  1  result saturated, or input was Inf/NaN.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (rst).
- Reset values: every stage-valid bit clears, so out_valid=0, out_data=0, out_ovf=0. in_ready=1 once rst deasserts.
- Reset mid-operation: all in-flight items are discarded. Nothing is emitted afterwards.
- Pipeline: S1 decodes and aligns; S2 rounds, negates and saturates. Latency is 2 cycles from the accepting edge to out_valid when unstalled. Throughput is 1 per cycle.
- Handshake:
  - Transfer occurs when valid && ready on the same edge.
  - s2_en = !s2_valid || out_ready; s1_en = !s1_valid || s2_en; in_ready = s1_en (combinational, no in_valid dependency).
  - Stalled stages hold their data.
  - Order is preserved; no drops or duplicates.
  - out_data/out_ovf stay stable while out_valid && !out_ready.
- Arithmetic: let M = {1, f} (24 bits) and sh = e - 150.
  - e=0 (zero/denormal) or e<=125: magnitude 0, ovf 0.
  - 126<=e<=149: mag = M >> (150-e). Add round bit = last bit shifted out (bit 150-e-1 of M). Right-shift amounts up to 24; compute in a 25-bit-wide path so that e=126 gives mag=1.
  - 150<=e<=157: mag = M << (e-150), max 0x7FFFFF80. No rounding.
  - e=158, s=1, f=0: result 0x80000000, ovf 0.
  - e>=158 otherwise, including Inf: saturate to 0x7fffffff (s=0) or 0x80000000 (s=1), ovf 1.
  - NaN: NAN_VAL, ovf 1.
  - Result = s ? -mag : mag. Negative zero yields 0.
- Simultaneous events:
  - Input accepted and output consumed on the same edge: both happen.
  - Full pipe with out_ready low: in_ready=0 the same cycle.

Decomposition:
- Shared package fpu_pkg:
  - EXP_BIAS=127, FTOI_EXP_ZERO=150, FTOI_EXP_MAX=158.
  - INT32_MAX/INT32_MIN constants.
  - Float field slice positions.
  - Struct type for the float fields {sign, exp, frac}.
- One sub-module, ftoi_round_shift (combinational): takes M and exp, returns unrounded magnitude plus round bit. Instantiated in S1 so the S1 register holds {sign, mag, rbit, class}.

Test Plan:
- 0x3FC00000 (1.5) -> 0x00000002; 0xBFC00000 -> 0xFFFFFFFE; 0x40200000 (2.5) -> 0x00000003. All ovf 0, 2 cycles after acceptance.
- 0x3F000000 (0.5) -> 1; 0x3EFFFFFF -> 0; 0x00000001 -> 0; 0x80000000 -> 0.
- 0x4EFFFFFF -> 0x7FFFFF80, ovf 0; 0xCF000000 -> 0x80000000, ovf 0; 0x4F000000 -> 0x7FFFFFFF, ovf 1; 0xFF800000 -> 0x80000000, ovf 1; 0x7FC00000 -> 0x7FFFFFFF, ovf 1.
- Stream 1.0..8.0 with in_valid held high; hold out_ready low for cycles 3-5.
  - in_ready drops after two items are buffered.
  - Outputs are 1..8 in order, with no loss or duplication, and out_data stable during the stall.
- Assert rst asynchronously between edges with 2 items in flight. out_valid drops immediately; no stale item appears after release.
- Random |x|<2^24 passed through the integer-to-float unit then this block -> returns x exactly.
